serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
- Transmit-side serial device: the CPU→host half of the serial link.
- Sits behind the IO manager on the serial port (mode/addr/wdata/rdata).
- Buffers bytes written by the CPU in a small FIFO and shifts them out on a single 8N1 line (monitor responses, console output).
- Exposes a status word so software can poll for space and idle.

Parameters:
- CLK_DIV, 16: clock cycles per serial bit (≥2).
- FIFO_DEPTH, 4: byte FIFO entries (power of two, ≥2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- mode  input  2  access type: 0 none, 1 read, 2 write, 3 treated as none.
- addr  input  32  byte address; only addr[2] decoded (0 = DATA, 1 = STATUS).
- wdata  input  32  write data; only [7:0] used.
- rdata  output  32  read data, combinational.
- txd  output  1  serial line; idle high.
- busy  output  1  high when FIFO non-empty or shifter not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO empty; state IDLE; txd=1; busy=0; overflow flag=0; bit/cycle counters=0.
  - rdata reflects post-reset status (0x3 on STATUS).
  - Reset mid-frame aborts the frame immediately and drives txd=1.
- Write, mode=2, addr[2]=0:
  - Push wdata[7:0] at the clock edge if count<FIFO_DEPTH.
  - If full, drop the byte and set the sticky overflow flag.
  - Fullness is evaluated before any same-cycle pop, so a write to a full FIFO is dropped even if a pop happens that cycle.
- Write, mode=2, addr[2]=1: ignored.
- Read, mode=1:
  - DATA: rdata=0.
  - STATUS: rdata = {29'b0, overflow, idle, not_full}.
    - not_full = count<FIFO_DEPTH.
    - idle = FIFO empty and state IDLE.
  - At the edge ending a STATUS read, overflow clears. If a dropped write coincides, set wins.
- Mode 0 or 3: rdata=0, no side effects.
- FIFO:
  - Circular; read/write pointers wrap modulo FIFO_DEPTH.
  - count ranges 0..FIFO_DEPTH.
  - Simultaneous push and pop on a non-full FIFO: count unchanged, both pointers advance.
- Transmit FSM, states IDLE, START, DATA, STOP:
  - IDLE: txd=1. If FIFO non-empty at the edge: pop the head into the shift register, cycle counter=0, go to START.
  - START: txd=0 for CLK_DIV cycles, then DATA with bit index 0.
  - DATA: txd=shift[0] (LSB first). Hold CLK_DIV cycles, then shift right and increment the index. After bit 7, go to STOP.
  - STOP: txd=1 for CLK_DIV cycles. At the last cycle:
    - FIFO non-empty: pop and go directly to START (back-to-back frames, no idle gap).
    - Otherwise: go to IDLE.
- Timing:
  - Frame length: exactly 10*CLK_DIV cycles.
  - A write at edge N into an empty, idle block gives txd=0 from edge N+1.
  - Last stop bit ends at edge N+1+10*CLK_DIV.
- txd and busy are registered outputs (no glitches).
- Counters are sized ceil(log2(CLK_DIV)) and wrap to 0 at CLK_DIV-1.

Test Plan:
- Reset check: rst low then high → txd=1, busy=0; STATUS read gives rdata=0x00000003.
- Single byte, CLK_DIV=4: write 0x47 ('G') at edge N → txd pattern 0,1,1,1,0,0,0,1,0,1, each bit held 4 cycles, starting edge N+1; busy falls at edge N+41.
- Back-to-back: write 0x00 then 0x80 on consecutive cycles → two 40-cycle frames with no idle between; second frame data bits 0000000 then 1.
- Overflow, FIFO_DEPTH=4, CLK_DIV=16:
  - 6 consecutive writes 0x10..0x15 → first popped by the FSM, 4 buffered, 6th dropped.
  - STATUS then reads 0x4 (overflow=1, idle=0, not_full=0).
  - A second STATUS read returns overflow=0.
  - Only bytes 0x10..0x14 appear on txd.
- Pointer wrap: stream 9 bytes 0x52,0x01..0x08 with polling of not_full between writes → all 9 bytes appear in order on txd; FIFO pointers wrap twice.
- Reset mid-frame: assert rst during the DATA bit 3 of 0xA5 → txd=1 immediately (asynchronous), FIFO empty. After release, a new write 0x52 transmits cleanly.

Source files
------------

// File: rtl/serial_tx.sv
// serial_tx: CPU-to-host 8N1 transmitter with a small byte FIFO
// and a pollable status word behind the IO manager port.
module serial_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        busy
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] CLAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CONE  = CW'(1);
  localparam logic [PW:0]   DEPTH = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   NONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PONE  = PW'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          ovf_q;
  logic          txd_d, busy_d;

  logic wr_data, rd_stat;
  logic empty, full;
  logic push, pop, drop;
  logic [7:0] head;

  logic unused;
  assign unused = ^{addr[31:3], addr[1:0], wdata[31:8]};

  assign wr_data = (mode == 2'd2) && !addr[2];
  assign rd_stat = (mode == 2'd1) && addr[2];
  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH);
  assign push    = wr_data && !full;
  assign drop    = wr_data && full;
  assign head    = mem[rptr_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CLAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CONE;
        end
      end
      DATA: begin
        if (cnt_q == CLAST) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CONE;
        end
      end
      STOP: begin
        if (cnt_q == CLAST) begin
          cnt_d = '0;
          // back-to-back frames: reload without an idle gap
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CONE;
        end
      end
      default: state_d = IDLE;
    endcase

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + NONE;
      2'b01:   count_d = count_q - NONE;
      default: count_d = count_q;
    endcase

    txd_d = 1'b1;
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase

    busy_d = (count_d != '0) || (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
      txd     <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      count_q <= count_d;
      txd     <= txd_d;
      busy    <= busy_d;
      if (push) wptr_q <= wptr_q + PONE;
      if (pop)  rptr_q <= rptr_q + PONE;
      // a dropped write beats the clear-on-read
      if (drop)         ovf_q <= 1'b1;
      else if (rd_stat) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= wdata[7:0];
  end

  always_comb begin
    rdata = '0;
    if (rd_stat) begin
      rdata = {29'b0, ovf_q, empty && (state_q == IDLE), !full};
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: randomized scoreboard bench; a UART-style line
// decoder checks every frame against bytes the bench expects.
module tb_serial_tx;

  localparam int CD    = 4;
  localparam int DEPTH = 4;
  localparam int FL    = 10 * CD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        txd;
  logic        busy;

  serial_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mode(mode), .addr(addr),
    .wdata(wdata), .rdata(rdata), .txd(txd), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  int starts[$];
  int ncyc = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // line monitor: sample mid-cycle, collect one frame's worth
  initial begin : mon
    logic samp [FL];
    logic act;
    int   n;
    logic ok;
    logic [7:0] b;
    act = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst) begin
        act = 1'b0;
      end else if (!act) begin
        if (txd === 1'b0) begin
          act = 1'b1;
          samp[0] = txd;
          n = 1;
          starts.push_back(ncyc);
        end
      end else begin
        samp[n] = txd;
        n++;
        if (n == FL) begin
          act = 1'b0;
          ok = 1'b1;
          for (int i = 0; i < 10; i++)
            for (int j = 1; j < CD; j++)
              if (samp[i*CD+j] !== samp[i*CD]) ok = 1'b0;
          for (int i = 0; i < 8; i++) b[i] = samp[(i+1)*CD];
          chk("frame_shape", {29'b0, ok, samp[0], samp[9*CD]}, 32'h5);
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_frame: got 0x%0h expected none", b);
          end else begin
            chk("tx_byte", {24'b0, b}, {24'b0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b, input logic [31:0] a,
                    input logic [1:0] m);
    mode  = m;
    addr  = a;
    wdata = {$urandom_range(0, 32'hffffff), b};
    cyc();
    mode = 2'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    mode = 2'd1;
    addr = a;
    #1;
    v = rdata;
    cyc();
    mode = 2'd0;
  endtask

  task automatic poll_write(input logic [7:0] b);
    logic [31:0] s;
    int k;
    k = 0;
    rd(32'h4, s);
    chk("ovf_idle", {31'b0, s[2]}, 32'h0);
    while (!s[0] && k < 500) begin
      rd(32'h4, s);
      k++;
    end
    if (s[0]) begin
      exp_q.push_back(b);
      wr(b, 32'h0, 2'd2);
    end else begin
      chk("poll_timeout", {31'b0, s[0]}, 32'h1);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 3000) begin
      cyc();
      k++;
    end
    chk("drain", {31'b0, busy}, 32'h0);
    cyc();
    chk("exp_empty", exp_q.size(), 32'h0);
  endtask

  initial begin : wd
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] v;
    int occ;
    logic [7:0] wrap_b [9];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", {31'b0, txd}, 32'h1);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b1;
    cyc();
    rd(32'h4, v);
    chk("rst_status", v, 32'h3);
    rd(32'h0, v);
    chk("data_read", v, 32'h0);
    mode = 2'd3;
    addr = 32'h4;
    #1;
    chk("mode3_read", rdata, 32'h0);
    cyc();
    mode = 2'd0;

    // single byte: start edge and busy fall
    exp_q.push_back(8'h47);
    wr(8'h47, 32'h0, 2'd2);
    chk("n0_busy", {31'b0, busy}, 32'h1);
    chk("n0_txd", {31'b0, txd}, 32'h1);
    cyc();
    chk("n1_txd", {31'b0, txd}, 32'h0);
    repeat (39) cyc();
    chk("n40_busy", {31'b0, busy}, 32'h1);
    chk("n40_txd", {31'b0, txd}, 32'h1);
    cyc();
    chk("n41_busy", {31'b0, busy}, 32'h0);
    wait_idle();

    // back-to-back frames
    starts.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h80);
    wr(8'h00, 32'h0, 2'd2);
    wr(8'h80, 32'h0, 2'd2);
    wait_idle();
    chk("b2b_frames", starts.size(), 32'h2);
    if (starts.size() >= 2)
      chk("b2b_gap", starts[1] - starts[0], FL);

    // overflow: occupancy model, first byte leaves one cycle later
    occ = 0;
    for (int i = 0; i < 6; i++) begin
      if (occ < DEPTH) begin
        exp_q.push_back(8'(8'h10 + i));
        occ++;
      end
      if (i == 1) occ--;
      wr(8'(8'h10 + i), 32'h0, 2'd2);
    end
    rd(32'h4, v);
    chk("ovf_status1", v, 32'h4);
    rd(32'h4, v);
    chk("ovf_status2", v, 32'h0);
    wait_idle();

    // pointer wrap with polling
    wrap_b = '{8'h52, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h06, 8'h07, 8'h08};
    for (int i = 0; i < 9; i++) poll_write(wrap_b[i]);
    wait_idle();

    // randomized traffic, ignored accesses interleaved
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0, 1: poll_write(8'($urandom));
        2: begin
          rd(32'h0, v);
          chk("rnd_data_read", v, 32'h0);
        end
        3: begin
          wr(8'($urandom), 32'h4, 2'd2);
          wr(8'($urandom), 32'h0, 2'd3);
        end
        default: repeat ($urandom_range(0, 30)) cyc();
      endcase
    end
    wait_idle();

    // reset during data bit 3 of 0xA5
    wr(8'hA5, 32'h0, 2'd2);
    repeat (18) cyc();
    chk("a5_bit3", {31'b0, txd}, 32'h0);
    rst = 1'b0;
    #1;
    chk("midrst_txd", {31'b0, txd}, 32'h1);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rd(32'h4, v);
    chk("midrst_status", v, 32'h3);
    exp_q.push_back(8'h52);
    wr(8'h52, 32'h0, 2'd2);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
